// File: rtl/rgb_stream_unpacker.sv
// Unpacks a 64-bit little-endian RGB888 byte stream into 24-bit pixels with frame/line markers.
// Optional: define UNPACK_FRAME_CNT_EN to add the frame_cnt output (eof handshake counter).
module rgb_stream_unpacker #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 720,
   parameter int X_W      = 11,
   parameter int Y_W      = 10
) (
   input  logic        m_axi_acp_aclk,
   input  logic        axi_resetn,
   input  logic        enable,
   input  logic [63:0] mm2s_data,
   input  logic        mm2s_valid,
   output logic        mm2s_ready,
   output logic [23:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_sof,
   output logic        pix_eol,
   output logic        pix_eof,
   output logic        busy,
   output logic        resid_drop
`ifdef UNPACK_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
   localparam logic [X_W-1:0] X_ONE  = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

   state_t         r_state, w_state_nxt;
   logic [7:0]     r_buf [16];
   logic [7:0]     w_buf_nxt [16];
   logic [4:0]     r_cnt, w_cnt_nxt, w_base;
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic           r_resid_drop;
   logic           w_pop, w_push, w_frame_end, w_last_x, w_last_y;

   assign w_pop       = pix_valid & pix_ready;
   assign w_push      = mm2s_valid & mm2s_ready;
   assign w_frame_end = w_pop & pix_eof;

   always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
      if (!axi_resetn) r_state <= S_IDLE;
      else             r_state <= w_state_nxt;
   end

   // A frame in flight always completes; enable is only consulted at its end.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (enable) w_state_nxt = S_RUN;
         S_RUN:   if (w_frame_end && !enable) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state == S_RUN);
      mm2s_ready = busy && (r_cnt <= 5'd8);
      pix_valid  = busy && (r_cnt >= 5'd3);
      pix_data   = {r_buf[2], r_buf[1], r_buf[0]};
      w_last_x   = (r_x == X_LAST);
      w_last_y   = (r_y == Y_LAST);
      pix_sof    = pix_valid && (r_x == '0) && (r_y == '0);
      pix_eol    = pix_valid && w_last_x;
      pix_eof    = pix_eol && w_last_y;
      resid_drop = r_resid_drop;
   end

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      w_buf_nxt = r_buf;
      w_base    = r_cnt;
      if (w_pop) begin
         for (int i = 0; i < 13; i++) w_buf_nxt[i] = r_buf[i+3];
         for (int i = 13; i < 16; i++) w_buf_nxt[i] = 8'h00;
         w_base = r_cnt - 5'd3;
      end
      // Leftover bytes at frame end are discarded; a word arriving in the same cycle starts the next frame.
      if (w_frame_end) w_base = 5'd0;
      if (w_push) begin
         for (int i = 0; i < 8; i++) w_buf_nxt[4'(w_base + 5'(i))] = mm2s_data[8*i +: 8];
      end
      w_cnt_nxt = w_base + (w_push ? 5'd8 : 5'd0);
   end

   // NOTE: the byte buffer is reset as well, because pix_data is driven straight from it.
   always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         for (int i = 0; i < 16; i++) r_buf[i] <= 8'h00;
         r_cnt        <= 5'd0;
         r_resid_drop <= 1'b0;
      end else begin
         r_buf        <= w_buf_nxt;
         r_cnt        <= w_cnt_nxt;
         r_resid_drop <= w_frame_end && (r_cnt > 5'd3);
      end
   end

   always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_pop) begin
         if (w_last_x) begin
            r_x <= '0;
            r_y <= w_last_y ? '0 : r_y + Y_ONE;
         end else begin
            r_x <= r_x + X_ONE;
         end
      end
   end

`ifdef UNPACK_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
      if (!axi_resetn)      r_frame_cnt <= 16'd0;
      else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_rgb_stream_unpacker.sv
// Self-checking bench: two unpacker instances (4x2 and 3x1 frames) share stimulus and are
// compared every cycle against a byte-queue reference model, plus directed scenario checks.
module tb_rgb_stream_unpacker;

   localparam int HA [2] = '{4, 3};
   localparam int VA [2] = '{2, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [63:0] mm2s_data;
   logic        mm2s_valid;
   logic        pix_ready;

   logic        o_rdy  [2];
   logic [23:0] o_data [2];
   logic        o_vld  [2];
   logic        o_sof  [2];
   logic        o_eol  [2];
   logic        o_eof  [2];
   logic        o_busy [2];
   logic        o_drop [2];
`ifdef UNPACK_FRAME_CNT_EN
   logic [15:0] o_fc   [2];
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0]  mq [2][$];
   bit          m_run  [2];
   int          m_pix  [2];
   bit          m_drop [2];
   logic [15:0] m_fcnt [2];

   logic [23:0] cap_data [$];
   logic [2:0]  cap_mark [$];
   int          drops_b;

   always #5 clk = ~clk;

   rgb_stream_unpacker #(.H_ACTIVE(4), .V_ACTIVE(2), .X_W(2), .Y_W(1)) u_a (
      .m_axi_acp_aclk(clk), .axi_resetn(rst_n), .enable(enable),
      .mm2s_data(mm2s_data), .mm2s_valid(mm2s_valid), .mm2s_ready(o_rdy[0]),
      .pix_data(o_data[0]), .pix_valid(o_vld[0]), .pix_ready(pix_ready),
      .pix_sof(o_sof[0]), .pix_eol(o_eol[0]), .pix_eof(o_eof[0]),
      .busy(o_busy[0]), .resid_drop(o_drop[0])
`ifdef UNPACK_FRAME_CNT_EN
      , .frame_cnt(o_fc[0])
`endif
   );

   rgb_stream_unpacker #(.H_ACTIVE(3), .V_ACTIVE(1), .X_W(2), .Y_W(1)) u_b (
      .m_axi_acp_aclk(clk), .axi_resetn(rst_n), .enable(enable),
      .mm2s_data(mm2s_data), .mm2s_valid(mm2s_valid), .mm2s_ready(o_rdy[1]),
      .pix_data(o_data[1]), .pix_valid(o_vld[1]), .pix_ready(pix_ready),
      .pix_sof(o_sof[1]), .pix_eol(o_eol[1]), .pix_eof(o_eof[1]),
      .busy(o_busy[1]), .resid_drop(o_drop[1])
`ifdef UNPACK_FRAME_CNT_EN
      , .frame_cnt(o_fc[1])
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         m_run[k]  = 1'b0;
         m_pix[k]  = 0;
         m_drop[k] = 1'b0;
         m_fcnt[k] = 16'd0;
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_ready%0d", tag, k), 32'(o_rdy[k]), 32'd0);
         check($sformatf("%s_valid%0d", tag, k), 32'(o_vld[k]), 32'd0);
         check($sformatf("%s_data%0d", tag, k), 32'(o_data[k]), 32'd0);
         check($sformatf("%s_sof%0d", tag, k), 32'(o_sof[k]), 32'd0);
         check($sformatf("%s_eol%0d", tag, k), 32'(o_eol[k]), 32'd0);
         check($sformatf("%s_eof%0d", tag, k), 32'(o_eof[k]), 32'd0);
         check($sformatf("%s_busy%0d", tag, k), 32'(o_busy[k]), 32'd0);
         check($sformatf("%s_drop%0d", tag, k), 32'(o_drop[k]), 32'd0);
`ifdef UNPACK_FRAME_CNT_EN
         check($sformatf("%s_fcnt%0d", tag, k), 32'(o_fc[k]), 32'd0);
`endif
      end
   endtask

   // Compare both DUTs against the model, advance the model with the current inputs, then clock.
   task automatic tick();
      for (int k = 0; k < 2; k++) begin
         int   n;
         bit   e_rdy, e_vld, e_sof, e_eol, e_eof, pop, push, eofhs;
         n     = mq[k].size();
         e_rdy = m_run[k] && (n <= 8);
         e_vld = m_run[k] && (n >= 3);
         e_sof = e_vld && (m_pix[k] == 0);
         e_eol = e_vld && ((m_pix[k] % HA[k]) == HA[k] - 1);
         e_eof = e_vld && (m_pix[k] == HA[k] * VA[k] - 1);
         check($sformatf("ready%0d", k), 32'(o_rdy[k]), 32'(e_rdy));
         check($sformatf("valid%0d", k), 32'(o_vld[k]), 32'(e_vld));
         check($sformatf("sof%0d", k), 32'(o_sof[k]), 32'(e_sof));
         check($sformatf("eol%0d", k), 32'(o_eol[k]), 32'(e_eol));
         check($sformatf("eof%0d", k), 32'(o_eof[k]), 32'(e_eof));
         check($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_run[k]));
         check($sformatf("drop%0d", k), 32'(o_drop[k]), 32'(m_drop[k]));
         if (e_vld) check($sformatf("data%0d", k), 32'(o_data[k]), 32'({mq[k][2], mq[k][1], mq[k][0]}));
`ifdef UNPACK_FRAME_CNT_EN
         check($sformatf("fcnt%0d", k), 32'(o_fc[k]), 32'(m_fcnt[k]));
`endif
         if (k == 0 && o_vld[0] && pix_ready) begin
            cap_data.push_back(o_data[0]);
            cap_mark.push_back({o_sof[0], o_eol[0], o_eof[0]});
         end
         if (k == 1 && o_drop[1]) drops_b++;

         pop       = e_vld && pix_ready;
         push      = e_rdy && mm2s_valid;
         eofhs     = pop && e_eof;
         m_drop[k] = eofhs && (n > 3);
         if (pop) begin
            for (int i = 0; i < 3; i++) void'(mq[k].pop_front());
            m_pix[k] = (m_pix[k] + 1) % (HA[k] * VA[k]);
         end
         if (eofhs) begin
            mq[k].delete();
            m_fcnt[k] = m_fcnt[k] + 16'd1;
         end
         if (push) for (int i = 0; i < 8; i++) mq[k].push_back(mm2s_data[8*i +: 8]);
         if (!m_run[k]) m_run[k] = enable;
         else if (eofhs && !enable) m_run[k] = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      mm2s_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic send_word(input logic [63:0] w);
      bit done = 1'b0;
      mm2s_data  = w;
      mm2s_valid = 1'b1;
      for (int t = 0; t < 20 && !done; t++) begin
         done = o_rdy[0];
         tick();
      end
      if (!done) check("send_timeout", 32'd0, 32'd1);
      mm2s_valid = 1'b0;
   endtask

   initial begin
      logic [23:0] exp_pix [5];
      exp_pix = '{24'h020100, 24'h050403, 24'h080706, 24'h0B0A09, 24'h0E0D0C};

      rst_n      = 1'b0;
      enable     = 1'b0;
      mm2s_data  = 64'd0;
      mm2s_valid = 1'b0;
      pix_ready  = 1'b0;
      drops_b    = 0;
      model_reset();
      #1;
      check_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Byte order on the 4x2 instance; the 3x1 instance sees an eof with 7 bytes left over.
      enable    = 1'b1;
      pix_ready = 1'b1;
      tick();
      mm2s_data  = 64'h0706050403020100;
      mm2s_valid = 1'b1;
      tick();
      mm2s_data = 64'h0F0E0D0C0B0A0908;
      tick();
      mm2s_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("byte_order_count", 32'(cap_data.size()), 32'd5);
      for (int i = 0; i < 5 && i < cap_data.size(); i++)
         check($sformatf("byte_order_pix%0d", i), 32'(cap_data[i]), 32'(exp_pix[i]));
      check("byte_order_cnt", 32'(u_a.r_cnt), 32'd1);
      check("resid_pulses", 32'(drops_b), 32'd1);
      check("resid_cnt", 32'(u_b.r_cnt), 32'd0);

      // Async reset mid-line, no clock edge in between.
      mm2s_data  = {$urandom, $urandom};
      mm2s_valid = 1'b1;
      pix_ready  = 1'b0;
      tick();
      mm2s_valid = 1'b0;
      pix_ready  = 1'b1;
      tick();
      check("pre_reset_x", 32'(u_a.r_x), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      tick();

      // Backpressure: two words buffer, then the input stalls.
      pix_ready  = 1'b0;
      mm2s_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         mm2s_data = {$urandom, $urandom};
         tick();
      end
      check("bp_cnt", 32'(u_a.r_cnt), 32'd16);
      check("bp_ready", 32'(o_rdy[0]), 32'd0);
      check("bp_first_sof", 32'(o_sof[0]), 32'd1);
      mm2s_valid = 1'b0;
      pix_ready  = 1'b1;
      for (int i = 0; i < 8; i++) tick();

      // Markers: one 4x2 frame, enable dropped so the FSM returns to idle at eof.
      do_reset();
      enable = 1'b1;
      tick();
      enable = 1'b0;
      cap_data.delete();
      cap_mark.delete();
      for (int w = 0; w < 3; w++) send_word({$urandom, $urandom});
      for (int i = 0; i < 10; i++) tick();
      check("mark_count", 32'(cap_mark.size()), 32'd8);
      for (int i = 0; i < 8 && i < cap_mark.size(); i++)
         check($sformatf("mark_pix%0d", i), 32'(cap_mark[i]),
               32'({i == 0, (i % 4) == 3, i == 7}));
      check("mark_busy", 32'(o_busy[0]), 32'd0);
      check("mark_ready", 32'(o_rdy[0]), 32'd0);

`ifdef UNPACK_FRAME_CNT_EN
      // Three back-to-back frames with enable held high.
      do_reset();
      enable     = 1'b1;
      pix_ready  = 1'b1;
      mm2s_valid = 1'b1;
      for (int t = 0; t < 200 && m_fcnt[0] != 16'd3; t++) begin
         mm2s_data = {$urandom, $urandom};
         tick();
      end
      mm2s_valid = 1'b0;
      check("frame_cnt3", 32'(o_fc[0]), 32'd3);
`endif

      // Random traffic, checked against the model every cycle.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         enable     = ($urandom_range(0, 15) != 0);
         mm2s_valid = ($urandom_range(0, 3) != 0);
         pix_ready  = ($urandom_range(0, 3) != 0);
         mm2s_data  = {$urandom, $urandom};
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
